// File: rtl/qbert_pkg.sv
// qbert_pkg: shared jump directions, layer state codes and pyramid edge constants for the Q*bert sprite path.
package qbert_pkg;
  typedef enum logic [2:0] {NONE = 3'd0, DOWN_RIGHT = 3'd1, DOWN_LEFT = 3'd2, UP_RIGHT = 3'd3, UP_LEFT = 3'd4} jump_dir_t;
  typedef enum logic [2:0] {QB_RESET = 3'd0, QB_JUMP = 3'd1, QB_LAND = 3'd2, QB_IDLE = 3'd3, QB_DEATH = 3'd4} qb_state_t;
  localparam logic [27:0] TOP = 28'h0000001;
  localparam logic [27:0] L_EDGE = 28'h020844B;
  localparam logic [27:0] R_EDGE = 28'h8104225;
  localparam logic [27:0] BOTTOM_ROW = 28'hFE00000;
  function automatic int cube_idx(input int r, input int c);
    return r * (r - 1) / 2 + c - 1;
  endfunction
endpackage

// File: rtl/qbert_cube_decode.sv
// qbert_cube_decode: maps a (row, col) pyramid coordinate to its one-hot cube vector.
import qbert_pkg::*;
module qbert_cube_decode #(
  parameter int N_CUBE = 28,
  parameter int RW = 3
) (
  input  logic [RW-1:0]     row,
  input  logic [RW-1:0]     col,
  output logic [N_CUBE-1:0] onehot
);
  assign onehot = N_CUBE'(1) << cube_idx(int'(row), int'(col));
endmodule

// File: rtl/qbert_jump_ctrl.sv
// qbert_jump_ctrl: turns direction commands into sprite-layer jump requests and tracks visited cubes.
// Define QBERT_REVISIT_TOGGLE_EN to make a revisit clear the cube's visited bit.
import qbert_pkg::*;
module qbert_jump_ctrl #(
  parameter int N_ROWS = 7,
  parameter int N_CUBE = 28,
  parameter int LAUNCH_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_start,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_dir,
  output logic              cmd_ready,
  input  logic              done_move,
  input  logic [2:0]        state_qb,
  output logic [N_CUBE-1:0] position_qb,
  output logic [N_CUBE-1:0] e_next_qb,
  output logic [2:0]        e_jump_qb,
  output logic              e_bad_jump,
  output logic [N_CUBE-1:0] visited,
  output logic              cubes_done,
  output logic              launch_err
);
  localparam int RW = $clog2(N_ROWS + 1);
  localparam int CW = $clog2(LAUNCH_TIMEOUT + 1);
  typedef enum logic [1:0] {READY, ISSUE, FLIGHT, RESPAWN} fsm_t;
  fsm_t st;
  jump_dir_t dir, jump;
  logic [RW-1:0] row, col, trow, tcol, nrow, ncol;
  logic [CW-1:0] cnt;
  logic cmd_ok, down, bad;
  logic [N_CUBE-1:0] vis_land;
  assign dir = jump_dir_t'(cmd_dir);
  assign cmd_ok = cmd_valid && cmd_dir >= 3'd1 && cmd_dir <= 3'd4;
  assign down = dir == DOWN_RIGHT || dir == DOWN_LEFT;
  assign bad = down ? row == RW'(N_ROWS) : dir == UP_RIGHT ? col == RW'(1) : col == row;
  // A bad jump targets the current cube so the layer animates off-pyramid from where it stands
  assign nrow = bad ? row : down ? row + RW'(1) : row - RW'(1);
  assign ncol = bad ? col : dir == DOWN_LEFT ? col + RW'(1) : dir == UP_RIGHT ? col - RW'(1) : col;
`ifdef QBERT_REVISIT_TOGGLE_EN
  assign vis_land = visited ^ e_next_qb;
`else
  assign vis_land = visited | e_next_qb;
`endif
  assign cmd_ready = st == READY;
  assign e_jump_qb = jump;
  qbert_cube_decode #(.N_CUBE(N_CUBE), .RW(RW)) u_pos (.row(row), .col(col), .onehot(position_qb));
  qbert_cube_decode #(.N_CUBE(N_CUBE), .RW(RW)) u_tgt (.row(trow), .col(tcol), .onehot(e_next_qb));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= READY;
      jump <= NONE;
      {row, col, trow, tcol} <= {RW'(1), RW'(1), RW'(1), RW'(1)};
      cnt <= '0;
      e_bad_jump <= 1'b0;
      visited <= N_CUBE'(1);
      cubes_done <= 1'b0;
      launch_err <= 1'b0;
    end else if (e_start) begin
      st <= READY;
      jump <= NONE;
      {row, col, trow, tcol} <= {RW'(1), RW'(1), RW'(1), RW'(1)};
      cnt <= '0;
      e_bad_jump <= 1'b0;
      visited <= N_CUBE'(1);
      cubes_done <= 1'b0;
      launch_err <= 1'b0;
    end else begin
      cubes_done <= &visited;
      case (st)
        READY: if (cmd_ok) begin
          jump <= dir;
          trow <= nrow;
          tcol <= ncol;
          e_bad_jump <= bad;
          cnt <= '0;
          st <= ISSUE;
        end
        ISSUE: if (!done_move) st <= FLIGHT;
          else if (cnt == CW'(LAUNCH_TIMEOUT - 1)) begin
            launch_err <= 1'b1;
            jump <= NONE;
            trow <= row;
            tcol <= col;
            st <= READY;
          end else cnt <= cnt + CW'(1);
        FLIGHT: if (done_move) begin
          jump <= NONE;
          if (e_bad_jump) st <= RESPAWN;
          else begin
            row <= trow;
            col <= tcol;
            visited <= vis_land;
            st <= READY;
          end
        end
        RESPAWN: if (state_qb == QB_IDLE) begin
          {row, col, trow, tcol} <= {RW'(1), RW'(1), RW'(1), RW'(1)};
          e_bad_jump <= 1'b0;
          st <= READY;
        end
        default: st <= READY;
      endcase
    end
endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// tb_qbert_jump_ctrl: directed and randomized jumps checked against a pyramid-coordinate reference model.
module tb_qbert_jump_ctrl;
  logic clk = 1'b0, reset = 1'b0, e_start = 1'b0, cmd_valid = 1'b0, done_move = 1'b1;
  logic [2:0] cmd_dir = 3'd0, state_qb = 3'd3;
  logic cmd_ready, e_bad_jump, cubes_done, launch_err;
  logic [2:0] e_jump_qb;
  logic [27:0] position_qb, e_next_qb, visited;
  int checks = 0, failures = 0;
  int mr = 1, mc = 1;
  bit mvis [28];
  always #5 clk = ~clk;
  qbert_jump_ctrl dut (
    .clk(clk), .reset(reset), .e_start(e_start), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready), .done_move(done_move), .state_qb(state_qb), .position_qb(position_qb),
    .e_next_qb(e_next_qb), .e_jump_qb(e_jump_qb), .e_bad_jump(e_bad_jump), .visited(visited),
    .cubes_done(cubes_done), .launch_err(launch_err)
  );
  function automatic logic [27:0] oh(input int r, input int c);
    logic [27:0] v = '0;
    v[r * (r - 1) / 2 + c - 1] = 1'b1;
    return v;
  endfunction
  function automatic logic [27:0] vis_vec();
    logic [27:0] v;
    for (int i = 0; i < 28; i++) v[i] = mvis[i];
    return v;
  endfunction
  function automatic logic all_vis();
    for (int i = 0; i < 28; i++) if (!mvis[i]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic model_restart();
    mr = 1;
    mc = 1;
    for (int i = 0; i < 28; i++) mvis[i] = (i == 0);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic jump(input int d, input bit pre_low, input int fly, input int hold);
    int nr, nc, k;
    bit b;
    logic prev_done;
    nr = (d <= 2) ? mr + 1 : mr - 1;
    nc = (d == 2) ? mc + 1 : (d == 3) ? mc - 1 : mc;
    b = (d <= 2) ? (mr == 7) : (d == 3) ? (mc == 1) : (mc == mr);
    if (b) begin nr = mr; nc = mc; end
    done_move = !pre_low;
    cmd_valid = 1'b1;
    cmd_dir = 3'(d);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("issue_dir", e_jump_qb, d);
    chk("issue_bad", e_bad_jump, b);
    chk("issue_next", e_next_qb, oh(nr, nc));
    chk("issue_ready", cmd_ready, 0);
    done_move = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir = 3'($urandom_range(1, 4));
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (fly) @(negedge clk);
    chk("flight_next", e_next_qb, oh(nr, nc));
    chk("flight_pos", position_qb, oh(mr, mc));
    done_move = 1'b1;
    @(negedge clk);
    chk("land_jump", e_jump_qb, 0);
    if (!b) begin
      prev_done = all_vis();
      mr = nr;
      mc = nc;
      k = mr * (mr - 1) / 2 + mc - 1;
`ifdef QBERT_REVISIT_TOGGLE_EN
      mvis[k] = !mvis[k];
`else
      mvis[k] = 1'b1;
`endif
      chk("land_pos", position_qb, oh(mr, mc));
      chk("land_next", e_next_qb, oh(mr, mc));
      chk("land_vis", visited, vis_vec());
      chk("land_ready", cmd_ready, 1);
      chk("land_done_prev", cubes_done, prev_done);
      @(negedge clk);
      chk("land_done", cubes_done, all_vis());
    end else begin
      chk("resp_enter", cmd_ready, 0);
      state_qb = 3'd0;
      repeat (hold) @(negedge clk);
      chk("resp_hold", cmd_ready, 0);
      chk("resp_badhold", e_bad_jump, 1);
      state_qb = 3'd3;
      @(negedge clk);
      mr = 1;
      mc = 1;
      chk("resp_pos", position_qb, oh(1, 1));
      chk("resp_next", e_next_qb, oh(1, 1));
      chk("resp_bad", e_bad_jump, 0);
      chk("resp_ready", cmd_ready, 1);
      chk("resp_vis", visited, vis_vec());
    end
  endtask
  task automatic go_to(input int tr, input int tc);
    while (mr != 1) jump((mc < mr) ? 4 : 3, 1'b0, 0, 1);
    for (int i = 1; i < tc; i++) jump(2, 1'b0, 0, 1);
    for (int i = tc; i < tr; i++) jump(1, 1'b0, 0, 1);
  endtask
  task automatic restart();
    e_start = 1'b1;
    @(negedge clk);
    e_start = 1'b0;
    model_restart();
  endtask
  initial begin
    int n;
    model_restart();
    #12;
    chk("rst_pos", position_qb, 28'h1);
    chk("rst_vis", visited, 28'h1);
    chk("rst_jump", e_jump_qb, 0);
    chk("rst_err", launch_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_next", e_next_qb, 28'h1);
    chk("rst_done", cubes_done, 0);
    jump(2, 1'b0, 2, 1);
    chk("good_pos", position_qb, 28'h4);
    chk("good_vis", visited, 28'h5);
    restart();
    jump(3, 1'b0, 1, 50);
    for (int i = 0; i < 6; i++) jump(1, 1'b0, 0, 1);
    chk("bottom_pos", position_qb, 28'h0200000);
    jump(1, 1'b1, 1, 3);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_dir = (i == 0) ? 3'd0 : 3'(4 + i);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("inv_ready", cmd_ready, 1);
      chk("inv_jump", e_jump_qb, 0);
      chk("inv_next", e_next_qb, oh(mr, mc));
    end
    jump(2, 1'b0, 0, 1);
    done_move = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", (n >= 1023 && n <= 1025), 1);
    chk("to_err", launch_err, 1);
    chk("to_jump", e_jump_qb, 0);
    chk("to_next", e_next_qb, oh(mr, mc));
    chk("to_pos", position_qb, oh(mr, mc));
    jump(1, 1'b0, 1, 1);
    chk("to_sticky", launch_err, 1);
    restart();
    chk("start_err", launch_err, 0);
    chk("start_pos", position_qb, 28'h1);
    chk("start_vis", visited, 28'h1);
    cmd_valid = 1'b1;
    cmd_dir = 3'd2;
    e_start = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    e_start = 1'b0;
    chk("prio_ready", cmd_ready, 1);
    chk("prio_jump", e_jump_qb, 0);
    for (int r = 1; r <= 7; r++)
      for (int c = 1; c <= r; c++) go_to(r, c);
    chk("tour_done", cubes_done, all_vis());
    chk("tour_vis", visited, vis_vec());
    go_to(2, 2);
    chk("revisit_vis", visited, vis_vec());
    chk("revisit_done", cubes_done, all_vis());
    for (int i = 0; i < 60; i++)
      jump(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(1, 5)));
    chk("final_pos", position_qb, oh(mr, mc));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qbert_jump_ctrl.md
Name: qbert_jump_ctrl

Overview:
- Upstream stage of the Q*bert sprite layer; converts a single validated direction command into the jump request that layer consumes.
- Tracks Q*bert's cube on the 7-row, 28-cube pyramid and computes the one-hot target cube. Flags off-pyramid jumps as bad jumps.
- Sequences the jump against the layer's done_move handshake and keeps the visited-cube bitmap used for level completion.

Parameters:
- N_ROWS, 7, pyramid rows; cube count = N_ROWS*(N_ROWS+1)/2.
- N_CUBE, 28, one-hot width; must equal the cube count above.
- LAUNCH_TIMEOUT, 1024, cycles to wait for done_move to fall before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- e_start  in  1  synchronous restart pulse: Q*bert to TOP, bitmap cleared
- cmd_valid  in  1  direction command strobe
- cmd_dir  in  3  1 DOWN_RIGHT, 2 DOWN_LEFT, 3 UP_RIGHT, 4 UP_LEFT; others ignored
- cmd_ready  out  1  high only in READY
- done_move  in  1  from layer; 0 while moving, 1 when landed
- state_qb  in  3  layer state; 3'd3 = IDLE
- position_qb  out  N_CUBE  one-hot current cube
- e_next_qb  out  N_CUBE  one-hot target cube; equals position_qb on a bad jump
- e_jump_qb  out  3  direction presented to the layer; 0 = none
- e_bad_jump  out  1  current jump leaves the pyramid
- visited  out  N_CUBE  landed-on cubes
- cubes_done  out  1  all visited bits set
- launch_err  out  1  sticky; set on timeout, cleared by e_start

Behaviour:
- Cube index (row r 1..N_ROWS, col c 1..r): bit = r(r-1)/2 + c - 1. Held internally as row/col registers; position_qb and e_next_qb are decoded from them.
- Moves and their bad condition:
  - DOWN_RIGHT: (r+1, c); bad if r = N_ROWS.
  - DOWN_LEFT: (r+1, c+1); bad if r = N_ROWS.
  - UP_RIGHT: (r-1, c-1); bad if c = 1.
  - UP_LEFT: (r-1, c); bad if c = r.
- Reset values:
  - row = col = 1, so position_qb = e_next_qb = 32-bit-aligned TOP (bit 0).
  - e_jump_qb = 0, e_bad_jump = 0, visited = 1 (TOP), cubes_done = 0, launch_err = 0, FSM = READY.
- FSM:
  - READY: cmd_ready = 1. On cmd_valid with cmd_dir in 1..4 (one cycle), register the direction, compute target and bad flag, and go to ISSUE. Outputs are valid the next cycle. Invalid cmd_dir: stay in READY, no output change.
  - ISSUE: drive e_jump_qb, e_next_qb, e_bad_jump. Count cycles while done_move = 1.
    - done_move = 0: go to FLIGHT.
    - Count reaches LAUNCH_TIMEOUT: set launch_err, clear e_jump_qb, e_next_qb := position_qb, go to READY.
  - FLIGHT: wait for done_move = 1, then:
    - Good jump: row/col := target; set the visited bit for the new cube; e_jump_qb := 0; go to READY.
    - Bad jump: e_jump_qb := 0; go to RESPAWN.
  - RESPAWN: wait for state_qb = 3'd3. Then row = col = 1, e_next_qb = TOP, e_bad_jump := 0, go to READY. The bitmap is retained.
- cmd_valid outside READY is dropped (no queue).
- e_start in any state: same effect as reset, applied on the next edge. It has priority over every transition in the same cycle.
- cubes_done is registered: set one cycle after the last bitmap bit sets, held until e_start.
- position_qb never differs from e_next_qb outside ISSUE/FLIGHT, so the layer cannot re-trigger after landing.
- done_move already 0 on entry to ISSUE: go straight to FLIGHT the next cycle.

Optional Feature:
- Macro: QBERT_REVISIT_TOGGLE_EN.
- Defined: landing on a cube whose visited bit is already 1 clears that bit (advanced-level toggle); TOP's reset/restart value stays 1.
- Undefined: visited bits only ever set; a revisit has no effect.

Decomposition:
- Shared package qbert_pkg holds:
  - jump_dir_t enum: NONE = 0, DOWN_RIGHT = 1, DOWN_LEFT = 2, UP_RIGHT = 3, UP_LEFT = 4;
  - the layer state encodings (IDLE = 3'd3 etc.);
  - the TOP/Rxx/Lxx edge-cube constants, so the layer and this block share one definition.
- One natural sub-module, qbert_cube_decode: combinational (row, col) to one-hot N_CUBE. Instantiated twice, for position and target.

Test Plan:
- Reset: reset low then high → position_qb = 0x0000001, visited = 0x0000001, e_jump_qb = 0, cmd_ready = 1.
- Good jump: cmd_dir = 2 from TOP, done_move 1→0→1 → e_next_qb = 0x0000004 during flight; afterwards position_qb = 0x0000004, visited = 0x0000005, e_jump_qb = 0.
- Bad jump: at TOP, cmd_dir = 3 → e_bad_jump = 1, e_next_qb = 0x0000001; after landing, hold state_qb = 3'd0 for 50 cycles → still RESPAWN; state_qb = 3'd3 → position_qb = TOP, e_bad_jump = 0.
- Bottom edge: walk DOWN_RIGHT six times to cube 22 (bit 21 = 0x0200000); a seventh DOWN_RIGHT → e_bad_jump = 1.
- Timeout: issue a jump, hold done_move = 1 for 1024 cycles → launch_err = 1, e_jump_qb = 0, READY. cmd_valid during FLIGHT is ignored.
- Completion/toggle: visit all 28 cubes → cubes_done one cycle after the last landing. With QBERT_REVISIT_TOGGLE_EN, revisiting cube 3 clears bit 2 and cubes_done drops.
